// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NUM_REQ clients.
// One read per cycle, registered response slot tagged with the requester ID.
module regfile_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [DATA_W-1:0]         rd_data,
    input  logic                      wr_enable,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      resp_valid,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_data,
    input  logic                      resp_ready
);

    logic [ID_W-1:0]   ptr;
    logic              slot_free;
    logic              gnt_found;
    logic              gnt_valid;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   cand;
    logic [DATA_W-1:0] read_value;

    assign slot_free = !resp_valid || resp_ready;

    // Search from ptr upward; NUM_REQ is a power of two so the index wraps for free.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr + ID_W'(k);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        gnt_valid = gnt_found && slot_free && !reset;
    end

    always_comb begin
        req_ready = '0;
        if (gnt_valid) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign rd_addr = gnt_valid ? req_addr[gnt_idx*ADDR_W +: ADDR_W] : '0;

    // Register 0 is hardwired to zero; otherwise a same-cycle write wins over the mux.
    always_comb begin
        if (rd_addr == '0) begin
            read_value = '0;
        end else if (wr_enable && (wr_addr == rd_addr)) begin
            read_value = wr_data;
        end else begin
            read_value = rd_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            ptr        <= '0;
        end else if (gnt_valid) begin
            resp_valid <= 1'b1;
            resp_id    <= gnt_idx;
            resp_data  <= read_value;
            ptr        <= gnt_idx + ID_W'(1);
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter; a scoreboard queue is filled at grant
// time and drained by a monitor whenever a response is consumed.
module tb_regfile_read_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ADDR_W-1:0]         rd_addr;
    logic [DATA_W-1:0]         rd_data;
    logic                      wr_enable = 1'b0;
    logic [ADDR_W-1:0]         wr_addr = '0;
    logic [DATA_W-1:0]         wr_data = '0;
    logic                      resp_valid;
    logic [ID_W-1:0]           resp_id;
    logic [DATA_W-1:0]         resp_data;
    logic                      resp_ready = 1'b0;

    logic [DATA_W-1:0] regs [32];
    logic              force_rd = 1'b0;
    logic [DATA_W-1:0] force_val = '0;

    logic [ID_W+DATA_W-1:0] sb [$];
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign rd_data = force_rd ? force_val : regs[rd_addr];

    regfile_read_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_enable (wr_enable),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .resp_valid(resp_valid),
        .resp_id   (resp_id),
        .resp_data (resp_data),
        .resp_ready(resp_ready)
    );

    task automatic check_output(input string name, input logic [DATA_W-1:0] act,
                                input logic [DATA_W-1:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
        req_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic push_exp(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] data);
        sb.push_back({id, data});
    endtask

    // Monitor: every consumed response must match the oldest expected entry.
    initial begin
        logic [ID_W+DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && resp_valid === 1'b1 && resp_ready) begin
                if (sb.size() == 0) begin
                    check_output("spurious_resp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_output("resp_id", 32'(resp_id), 32'(e[DATA_W +: ID_W]));
                    check_output("resp_data", resp_data, e[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic apply_stimulus();
        int exp_gnt_rr [5] = '{0, 1, 2, 3, 0};
        logic [DATA_W-1:0] exp_dat_rr [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h11};
        logic [5:0] pat1 = 6'b011011;
        int exp_gnt_fair [6] = '{3, 1, 3, 1, 3, 3};
        int last3 = 0;
        int n;

        for (int r = 0; r < 32; r++) regs[r] = 32'(r * 32'h11);
        regs[5] = 32'h1234;
        regs[7] = 32'hDEADBEEF;

        // Reset state, with every request asserted
        #2 reset = 1'b1;
        req_valid = 4'hF;
        resp_ready = 1'b1;
        #2;
        check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_output("rst_resp_id", 32'(resp_id), 32'd0);
        check_output("rst_resp_data", resp_data, 32'd0);
        check_output("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;

        // Round robin over all four requesters
        for (int i = 0; i < 4; i++) set_addr(i, ADDR_W'(i + 1));
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_output("rr_req_ready", 32'(req_ready), 32'(1 << exp_gnt_rr[i]));
            push_exp(ID_W'(exp_gnt_rr[i]), exp_dat_rr[i]);
            tick();
            check_output("rr_latency_valid", 32'(resp_valid), 32'd1);
        end

        // Backpressure: slot holds (0, 0x11) and nothing is granted
        req_valid = 4'b0010;
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_output("bp_req_ready", 32'(req_ready), 32'd0);
            check_output("bp_resp_data", resp_data, 32'h11);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        check_output("bp_release_grant", 32'(req_ready), 32'b0010);
        push_exp(2'd1, 32'h22);
        tick();

        // Write bypass: requester 2 reads r5 while r5 is being written
        req_valid = 4'b0100;
        set_addr(2, 5'd5);
        wr_enable = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hCAFE0001;
        #1;
        check_output("byp_req_ready", 32'(req_ready), 32'b0100);
        check_output("byp_rd_addr", 32'(rd_addr), 32'd5);
        push_exp(2'd2, 32'hCAFE0001);
        tick();

        // Register 0 reads as zero regardless of write or mux contents
        req_valid = 4'b1000;
        set_addr(3, 5'd0);
        wr_addr = 5'd0;
        wr_data = 32'hFFFFFFFF;
        force_rd = 1'b1;
        force_val = 32'hAAAAAAAA;
        #1;
        check_output("zero_req_ready", 32'(req_ready), 32'b1000);
        check_output("zero_rd_addr", 32'(rd_addr), 32'd0);
        push_exp(2'd3, 32'h0);
        tick();
        force_rd = 1'b0;

        // Write to another register must not bypass
        req_valid = 4'b0001;
        set_addr(0, 5'd3);
        wr_addr = 5'd4;
        wr_data = 32'h55555555;
        #1;
        check_output("miss_req_ready", 32'(req_ready), 32'b0001);
        push_exp(2'd0, 32'h33);
        tick();
        wr_enable = 1'b0;

        // Move ptr to 2
        req_valid = 4'b0010;
        set_addr(1, 5'd1);
        #1;
        check_output("ptr2_req_ready", 32'(req_ready), 32'b0010);
        push_exp(2'd1, 32'h11);
        tick();

        // Fairness: requester 3 continuous, requester 1 intermittent
        set_addr(3, 5'd4);
        for (int c = 0; c < 6; c++) begin
            req_valid = {1'b1, 1'b0, pat1[c], 1'b0};
            #1;
            check_output("fair_req_ready", 32'(req_ready), 32'(1 << exp_gnt_fair[c]));
            if (req_ready[3]) begin
                check_output("fair_gap_le4", 32'((c - last3) <= 4), 32'd1);
                last3 = c;
                push_exp(2'd3, 32'h44);
            end else begin
                push_exp(2'd1, 32'h11);
            end
            tick();
        end

        // Reset mid-response: hold 0xDEADBEEF, then pulse reset between edges
        req_valid = 4'b0100;
        set_addr(2, 5'd7);
        #1;
        check_output("pre_rst_grant", 32'(req_ready), 32'b0100);
        push_exp(2'd2, 32'hDEADBEEF);
        tick();
        req_valid = '0;
        resp_ready = 1'b0;
        #1;
        check_output("pre_rst_data", resp_data, 32'hDEADBEEF);
        reset = 1'b1;
        #1;
        check_output("mid_rst_valid", 32'(resp_valid), 32'd0);
        check_output("mid_rst_data", resp_data, 32'd0);
        sb.delete();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) set_addr(i, ADDR_W'(i + 1));
        req_valid = 4'hF;
        resp_ready = 1'b1;
        #1;
        check_output("post_rst_grant", 32'(req_ready), 32'b0001);
        push_exp(2'd0, 32'h11);
        tick();
        req_valid = '0;

        // Drain the scoreboard with a bounded wait
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check_output("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        apply_stimulus();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
